// File: rtl/speedtest_capture_serializer.sv
// Speed-test capture: synchronises the classifier OUT bus, stores DEPTH decimated
// snapshots and shifts a selected word out MSB first. Optional macro: FIRST_HIT_EN.
module speedtest_capture_serializer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             start,
  input  logic [7:0]       decim,
  input  logic             rd_start,
  input  logic [AW-1:0]    rd_addr,
  output logic             busy,
  output logic             done,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
`ifdef FIRST_HIT_EN
  ,
  output logic [CNT_W-1:0] first_hit_time,
  output logic             first_hit_valid
`endif
);

  typedef enum logic {CAP_IDLE, CAP_RUN}  cap_state_t;
  typedef enum logic {RD_IDLE,  RD_SHIFT} rd_state_t;

  cap_state_t cap_state, cap_next;
  rd_state_t  rd_state,  rd_next;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [7:0]       period_m1;
  logic [7:0]       phase;
  logic [AW-1:0]    idx;
  logic             done_q;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;

  logic start_accept, wr_en, last_wr, last_bit, rd_accept;

  assign start_accept = start && (cap_state == CAP_IDLE);
  assign wr_en        = (cap_state == CAP_RUN) && (phase == 8'd0);
  assign last_wr      = wr_en && (idx == AW'(DEPTH - 1));
  assign last_bit     = (rd_state == RD_SHIFT) && (bit_cnt == BW'(WIDTH - 1));
  // A request on the final bit cycle chains the next word with no gap.
  assign rd_accept    = rd_start && !busy && !start_accept &&
                        ((rd_state == RD_IDLE) || last_bit);

  // Capture FSM
  always_ff @(posedge clk) begin
    if (reset) cap_state <= CAP_IDLE;
    else       cap_state <= cap_next;
  end

  // NOTE: every output and next-state value is defaulted first so no latch is inferred.
  always_comb begin
    cap_next = cap_state;
    busy     = 1'b0;
    case (cap_state)
      CAP_IDLE: if (start) cap_next = CAP_RUN;
      CAP_RUN: begin
        busy = 1'b1;
        if (last_wr) cap_next = CAP_IDLE;
      end
      default: cap_next = CAP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      period_m1 <= 8'd0;
      phase     <= 8'd0;
      idx       <= '0;
      done_q    <= 1'b0;
    end else begin
      sync1 <= Din;
      sync2 <= sync1;
      if (start_accept) begin
        period_m1 <= (decim == 8'd0) ? 8'd0 : decim - 8'd1;
        phase     <= 8'd0;
        idx       <= '0;
        done_q    <= 1'b0;
      end else if (wr_en) begin
        idx   <= idx + AW'(1);
        phase <= period_m1;
        if (last_wr) done_q <= 1'b1;
      end else if (cap_state == CAP_RUN) begin
        phase <= phase - 8'd1;
      end
    end
  end

  assign done = done_q;

  // NOTE: the snapshot memory has no reset; its contents are only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= sync2;
  end

  // Readout FSM
  always_ff @(posedge clk) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next    = rd_state;
    sout_valid = 1'b0;
    sout       = 1'b0;
    sout_last  = 1'b0;
    case (rd_state)
      RD_IDLE: if (rd_accept) rd_next = RD_SHIFT;
      RD_SHIFT: begin
        sout_valid = 1'b1;
        sout       = shreg[WIDTH-1];
        sout_last  = last_bit;
        if (last_bit) rd_next = rd_accept ? RD_SHIFT : RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (rd_accept) begin
      shreg   <= mem[rd_addr];
      bit_cnt <= '0;
    end else if (rd_state == RD_SHIFT) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

`ifdef FIRST_HIT_EN
  // Timestamp reads 1 in the cycle after start, so it equals cycles since start.
  logic [CNT_W-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt          <= '0;
      first_hit_time  <= '1;
      first_hit_valid <= 1'b0;
    end else begin
      if (start_accept)     ts_cnt <= CNT_W'(1);
      else if (ts_cnt != '1) ts_cnt <= ts_cnt + CNT_W'(1);

      if (start_accept) begin
        first_hit_time  <= '1;
        first_hit_valid <= 1'b0;
      end else if ((cap_state == CAP_RUN) && !first_hit_valid && (|sync2)) begin
        first_hit_time  <= ts_cnt;
        first_hit_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_speedtest_capture_serializer.sv
// Scoreboard bench: the driver queues expected serial words, a monitor rebuilds
// words from sout and compares them as they complete.
module tb_speedtest_capture_serializer;

  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int CNT_W = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] Din;
  logic             start;
  logic [7:0]       decim;
  logic             rd_start;
  logic [AW-1:0]    rd_addr;
  logic             busy, done, sout, sout_valid, sout_last;
`ifdef FIRST_HIT_EN
  logic [CNT_W-1:0] first_hit_time;
  logic             first_hit_valid;
`endif

  speedtest_capture_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Din(Din), .start(start), .decim(decim),
    .rd_start(rd_start), .rd_addr(rd_addr), .busy(busy), .done(done),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last)
`ifdef FIRST_HIT_EN
    , .first_hit_time(first_hit_time), .first_hit_valid(first_hit_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q [$];
  int nbits = 0;
  logic [WIDTH-1:0] word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One readout: queue the expected word, pulse rd_start, wait out the 64 bits.
  task automatic read_word(input logic [AW-1:0] a, input logic [WIDTH-1:0] e);
    exp_q.push_back(e);
    rd_addr  = a;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (WIDTH) tick();
  endtask

  // Pulse start, then observe cycles 1..ncyc after it.
  task automatic run_capture(input int ncyc, output int busy_cnt, output int done_cyc);
    busy_cnt = 0;
    done_cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_cyc == 0) done_cyc = c;
      tick();
    end
  endtask

  // Monitor
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        nbits = 0;
      end else if (sout_valid === 1'b1) begin
        word = {word[WIDTH-2:0], sout};
        nbits++;
        if (nbits == WIDTH) begin
          check("sout_last_on_bit0", {63'd0, sout_last}, 64'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected no output", word);
          end else begin
            e = exp_q.pop_front();
            check("serial_word", word, e);
          end
          nbits = 0;
        end else if (sout_last !== 1'b0) begin
          check("sout_last_early", {63'd0, sout_last}, 64'd0);
        end
      end else begin
        check("sout_idle", {62'd0, sout, sout_last}, 64'd0);
      end
    end
  end

  initial begin
    int bc, dc;
    reset = 1'b1; Din = '0; start = 1'b0; decim = 8'd1; rd_start = 1'b0; rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset after activity
    Din = 64'hDEAD_BEEF_0123_4567;
    decim = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sout_valid", {63'd0, sout_valid}, 64'd0);
    check("rst_sout_last", {63'd0, sout_last}, 64'd0);
`ifdef FIRST_HIT_EN
    check("rst_hit_valid", {63'd0, first_hit_valid}, 64'd0);
`endif
    reset = 1'b0;

    // Constant Din, decim=1: busy cycles 1..32, done from cycle 33
    Din = 64'hA5A5_0000_FFFF_1234;
    decim = 8'd1;
    repeat (3) tick();
    run_capture(40, bc, dc);
    check("d1_busy_cycles", 64'(bc), 64'd32);
    check("d1_done_cycle", 64'(dc), 64'd33);
    for (int a = 0; a < DEPTH; a++) read_word(AW'(a), 64'hA5A5_0000_FFFF_1234);

    // decim=2 with a second start and a read request at cycle 10: both ignored
    Din = 64'h0F0F_0F0F_0F0F_0F0F;
    decim = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    dc = 0;
    for (int c = 1; c <= 80; c++) begin
      if (busy === 1'b1) busy_cnt_inc: bc++;
      if (done === 1'b1 && dc == 0) dc = c;
      start    = (c == 10);
      rd_start = (c == 10);
      rd_addr  = '0;
      if (c == 20) decim = 8'd7;
      tick();
    end
    start = 1'b0;
    rd_start = 1'b0;
    check("d2_busy_cycles", 64'(bc), 64'd63);
    check("d2_done_cycle", 64'(dc), 64'd64);

    // decim=3, incrementing Din: snapshot k = max(3k-2, 0).
    // start and rd_start together from idle: start wins, no readout.
    Din = '0;
    decim = 8'd3;
    repeat (3) tick();
    start = 1'b1;
    rd_start = 1'b1;
    rd_addr = AW'(5);
    tick();
    start = 1'b0;
    rd_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      Din = 64'(c - 1);
      tick();
    end
    check("d3_done", {63'd0, done}, 64'd1);
    check("d3_busy", {63'd0, busy}, 64'd0);
    read_word(AW'(5), 64'd13);
    read_word(AW'(0), 64'd0);
    read_word(AW'(31), 64'd91);

    // Read word 7, retrigger mid-shift (ignored), then chain word 2 on the last-bit cycle
    exp_q.push_back(64'd19);
    exp_q.push_back(64'd4);
    rd_addr = AW'(7);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (30) tick();
    rd_addr = AW'(3);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (32) tick();
    check("last_bit_cycle", {62'd0, sout_valid, sout_last}, 64'd3);
    rd_addr = AW'(2);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (WIDTH) tick();
    check("chain_idle", {63'd0, sout_valid}, 64'd0);

`ifdef FIRST_HIT_EN
    // Bit 40 rises in cycle 12 after start -> seen after the 2-flop sync at 14
    Din = '0;
    decim = 8'd1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 12) Din = 64'h0000_0100_0000_0000;
      tick();
    end
    check("hit_valid", {63'd0, first_hit_valid}, 64'd1);
    check("hit_time", 64'(first_hit_time), 64'd14);

    Din = '0;
    repeat (3) tick();
    run_capture(40, bc, dc);
    check("nohit_valid", {63'd0, first_hit_valid}, 64'd0);
    check("nohit_time", 64'(first_hit_time), 64'h0000_0000_0000_FFFF);
`endif

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("no_partial_word", 64'(nbits), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
